// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if
// Groups the display-side sample bus and the decoded snapshot outputs.
//   seg, an, err_clr             : display bus and error clear (driven by master)
//   min1, min0, sec1, sec0       : published BCD digits
//   valid, blank, frame_done,
//   changed, locked, seg_err,
//   an_err                       : snapshot status and sticky error flags
interface seg_scan_decoder_if;
  logic [6:0] seg;
  logic [3:0] an;
  logic       err_clr;
  logic [3:0] min1;
  logic [3:0] min0;
  logic [3:0] sec1;
  logic [3:0] sec0;
  logic       valid;
  logic [3:0] blank;
  logic       frame_done;
  logic       changed;
  logic       locked;
  logic       seg_err;
  logic       an_err;

  modport master (
    output seg, an, err_clr,
    input  min1, min0, sec1, sec0, valid, blank, frame_done, changed,
           locked, seg_err, an_err
  );

  modport slave (
    input  seg, an, err_clr,
    output min1, min0, sec1, sec0, valid, blank, frame_done, changed,
           locked, seg_err, an_err
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Monitors a multiplexed active-low 7-segment display (anodes d0..d3 =
// sec0, sec1, min0, min1), locks onto the d0->d3 rotation, decodes each lit
// digit and publishes a full MM:SS snapshot once per scan frame.
//   fst_clk : scan clock (same clock that rotates the anodes)
//   rst     : synchronous reset, active-high
//   bus     : seg/an/err_clr in, digits + status/error flags out
//
// state  | meaning
// UNLOCK | waiting for d0 lit to start tracking the rotation
// LOCKED | following the rotation, slot exp expected this cycle
module seg_scan_decoder #(
  parameter int BLANK_HOLD = 2
) (
  input logic             fst_clk,
  input logic             rst,
  seg_scan_decoder_if.slave bus
);

  localparam int CW = $clog2(BLANK_HOLD + 1);
  localparam logic [CW-1:0] HOLD = CW'(BLANK_HOLD);

  typedef enum logic {UNLOCK, LOCKED} state_t;

  state_t          state, st_nxt;
  logic [1:0]      exp_slot, exp_nxt;
  logic [3:0]      shadow [4];
  logic [3:0]      sh_nxt [4];
  logic [CW-1:0]   cnt [4];
  logic [CW-1:0]   cnt_nxt [4];
  logic            first_frame;

  logic            is_lit, is_dark;
  logic [1:0]      lit_idx;
  logic [3:0]      dec;
  logic            dec_bad;
  logic            consume, capture, viol, relock, publish, diff;
  logic [3:0]      blank_nxt;

  always_comb begin
    is_lit  = 1'b1;
    lit_idx = 2'd0;
    case (bus.an)
      4'b1110: lit_idx = 2'd0;
      4'b1101: lit_idx = 2'd1;
      4'b1011: lit_idx = 2'd2;
      4'b0111: lit_idx = 2'd3;
      default: is_lit = 1'b0;
    endcase
    is_dark = (bus.an == 4'b1111);
  end

  always_comb begin
    dec_bad = 1'b0;
    case (bus.seg)
      7'b1000000: dec = 4'd0;
      7'b1111001: dec = 4'd1;
      7'b0100100: dec = 4'd2;
      7'b0110000: dec = 4'd3;
      7'b0011001: dec = 4'd4;
      7'b0010010: dec = 4'd5;
      7'b0000010: dec = 4'd6;
      7'b1111000: dec = 4'd7;
      7'b0000000: dec = 4'd8;
      7'b0010000: dec = 4'd9;
      default: begin
        dec     = 4'hF;
        dec_bad = 1'b1;
      end
    endcase
  end

  // Next shadow/counter values are computed here so the publish can copy
  // them straight into the outputs on the edge that consumes slot 3.
  always_comb begin
    sh_nxt  = shadow;
    cnt_nxt = cnt;
    exp_nxt = exp_slot;
    st_nxt  = state;
    consume = 1'b0;
    capture = 1'b0;
    viol    = 1'b0;
    relock  = 1'b0;
    case (state)
      UNLOCK: begin
        if (is_lit && lit_idx == 2'd0) begin
          sh_nxt[0]  = dec;
          cnt_nxt[0] = '0;
          exp_nxt    = 2'd1;
          st_nxt     = LOCKED;
          capture    = 1'b1;
          relock     = 1'b1;
        end
      end
      LOCKED: begin
        if (is_lit && lit_idx == exp_slot) begin
          sh_nxt[exp_slot]  = dec;
          cnt_nxt[exp_slot] = '0;
          consume           = 1'b1;
          capture           = 1'b1;
        end else if (is_dark) begin
          if (cnt[exp_slot] < HOLD)
            cnt_nxt[exp_slot] = cnt[exp_slot] + 1'b1;
          consume = 1'b1;
        end else begin
          viol   = 1'b1;
          st_nxt = UNLOCK;
        end
        if (consume)
          exp_nxt = exp_slot + 2'd1;
      end
      default: st_nxt = UNLOCK;
    endcase

    publish = consume && (exp_slot == 2'd3);
    for (int i = 0; i < 4; i++)
      blank_nxt[i] = (cnt_nxt[i] >= HOLD);
    diff = (sh_nxt[3] != bus.min1) || (sh_nxt[2] != bus.min0) ||
           (sh_nxt[1] != bus.sec1) || (sh_nxt[0] != bus.sec0);
  end

  always_ff @(posedge fst_clk) begin
    if (rst) begin
      state          <= UNLOCK;
      exp_slot       <= 2'd0;
      first_frame    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= 4'd0;
        cnt[i]    <= '0;
      end
      bus.min1       <= 4'd0;
      bus.min0       <= 4'd0;
      bus.sec1       <= 4'd0;
      bus.sec0       <= 4'd0;
      bus.blank      <= 4'd0;
      bus.valid      <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.changed    <= 1'b0;
      bus.locked     <= 1'b0;
      bus.seg_err    <= 1'b0;
      bus.an_err     <= 1'b0;
    end else begin
      state       <= st_nxt;
      exp_slot    <= exp_nxt;
      shadow      <= sh_nxt;
      cnt         <= cnt_nxt;
      bus.locked  <= (st_nxt == LOCKED);
      // A new error in the same cycle as err_clr keeps the flag set.
      bus.seg_err <= (capture && dec_bad) || (bus.seg_err && !bus.err_clr);
      bus.an_err  <= viol || (bus.an_err && !bus.err_clr);
      bus.frame_done <= publish;
      bus.changed    <= publish && diff && !first_frame;

      if (relock)
        first_frame <= 1'b1;
      else if (publish)
        first_frame <= 1'b0;

      if (viol)
        bus.valid <= 1'b0;
      else if (publish)
        bus.valid <= 1'b1;

      if (publish) begin
        bus.min1  <= sh_nxt[3];
        bus.min0  <= sh_nxt[2];
        bus.sec1  <= sh_nxt[1];
        bus.sec0  <= sh_nxt[0];
        bus.blank <= blank_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
// Directed bench for seg_scan_decoder with BLANK_HOLD = 2.
module tb_seg_scan_decoder;

  logic fst_clk = 1'b0;
  logic rst     = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  seg_scan_decoder_if bus ();

  seg_scan_decoder #(.BLANK_HOLD(2)) dut (
    .fst_clk (fst_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 fst_clk = ~fst_clk;

  localparam logic [3:0] AN0 = 4'b1110;
  localparam logic [3:0] AN1 = 4'b1101;
  localparam logic [3:0] AN2 = 4'b1011;
  localparam logic [3:0] AN3 = 4'b0111;
  localparam logic [3:0] DRK = 4'b1111;
  localparam logic [6:0] BADSEG = 7'b1111111;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [15:0] digits();
    return {bus.min1, bus.min0, bus.sec1, bus.sec0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic [3:0] a, input logic [6:0] s, input logic clr);
    @(negedge fst_clk);
    bus.an      = a;
    bus.seg     = s;
    bus.err_clr = clr;
    @(posedge fst_clk);
    #1;
  endtask

  task automatic frame(input int m1, input int m0, input int s1, input int s0);
    step(AN0, seg_of(s0), 1'b0);
    step(AN1, seg_of(s1), 1'b0);
    step(AN2, seg_of(m0), 1'b0);
    step(AN3, seg_of(m1), 1'b0);
  endtask

  initial begin
    bus.an      = DRK;
    bus.seg     = 7'b1111111;
    bus.err_clr = 1'b0;
    rst = 1'b1;
    step(DRK, BADSEG, 1'b0);
    step(DRK, BADSEG, 1'b0);
    rst = 1'b0;

    // reset state
    chk("rst_digits", 32'(digits()), 32'h0);
    chk("rst_flags", {26'd0, bus.valid, bus.frame_done, bus.changed, bus.locked, bus.seg_err, bus.an_err}, 32'h0);
    chk("rst_blank", 32'(bus.blank), 32'h0);

    // BAD while unlocked leaves an_err clear
    step(4'b0000, seg_of(1), 1'b0);
    chk("unlock_bad_an_err", 32'(bus.an_err), 32'h0);

    // 12:34 three frames
    step(AN0, seg_of(4), 1'b0);
    chk("lock_after_d0", 32'(bus.locked), 32'h1);
    step(AN1, seg_of(3), 1'b0);
    step(AN2, seg_of(2), 1'b0);
    chk("no_fd_mid", 32'(bus.frame_done), 32'h0);
    step(AN3, seg_of(1), 1'b0);
    chk("f1_fd", 32'(bus.frame_done), 32'h1);
    chk("f1_digits", 32'(digits()), 32'h1234);
    chk("f1_valid", 32'(bus.valid), 32'h1);
    chk("f1_changed", 32'(bus.changed), 32'h0);
    frame(1, 2, 3, 4);
    chk("f2_fd", 32'(bus.frame_done), 32'h1);
    chk("f2_changed", 32'(bus.changed), 32'h0);
    step(AN0, seg_of(4), 1'b0);
    chk("fd_one_cycle", 32'(bus.frame_done), 32'h0);
    step(AN1, seg_of(3), 1'b0);
    step(AN2, seg_of(2), 1'b0);
    step(AN3, seg_of(1), 1'b0);
    chk("f3_digits", 32'(digits()), 32'h1234);
    chk("f3_errs", {30'd0, bus.seg_err, bus.an_err}, 32'h0);

    // 59:59 then 00:00
    frame(5, 9, 5, 9);
    chk("5959_changed", 32'(bus.changed), 32'h1);
    chk("5959_digits", 32'(digits()), 32'h5959);
    frame(5, 9, 5, 9);
    chk("5959_steady", 32'(bus.changed), 32'h0);
    frame(0, 0, 0, 0);
    chk("0000_changed", {30'd0, bus.changed, bus.frame_done}, 32'h3);
    chk("0000_digits", 32'(digits()), 32'h0);
    step(AN0, seg_of(4), 1'b0);
    chk("changed_one_cycle", 32'(bus.changed), 32'h0);
    step(AN1, seg_of(3), 1'b0);
    step(AN2, seg_of(2), 1'b0);
    step(AN3, seg_of(1), 1'b0);
    chk("back_1234", 32'(digits()), 32'h1234);

    // slots 0,1 dark for two frames
    step(DRK, BADSEG, 1'b0);
    step(DRK, BADSEG, 1'b0);
    step(AN2, seg_of(2), 1'b0);
    step(AN3, seg_of(1), 1'b0);
    chk("blank_f1", 32'(bus.blank), 32'h0);
    chk("blank_f1_digits", 32'(digits()), 32'h1234);
    step(DRK, BADSEG, 1'b0);
    step(DRK, BADSEG, 1'b0);
    step(AN2, seg_of(2), 1'b0);
    step(AN3, seg_of(1), 1'b0);
    chk("blank_f2", 32'(bus.blank), 32'h3);
    chk("blank_f2_fd", 32'(bus.frame_done), 32'h1);
    chk("blank_f2_digits", 32'(digits()), 32'h1234);
    chk("blank_no_seg_err", 32'(bus.seg_err), 32'h0);
    frame(1, 2, 3, 4);
    chk("blank_cleared", 32'(bus.blank), 32'h0);

    // anode violation at exp=1
    step(AN0, seg_of(8), 1'b0);
    step(AN2, seg_of(3), 1'b0);
    chk("viol_state", {29'd0, bus.an_err, bus.locked, bus.valid}, 32'h4);
    chk("viol_frozen", 32'(digits()), 32'h1234);
    step(AN1, seg_of(3), 1'b0);
    chk("no_relock_d1", 32'(bus.locked), 32'h0);
    step(AN0, seg_of(7), 1'b0);
    chk("relock", 32'(bus.locked), 32'h1);
    step(AN1, seg_of(6), 1'b0);
    step(AN2, seg_of(5), 1'b0);
    step(AN3, seg_of(4), 1'b0);
    chk("relock_digits", 32'(digits()), 32'h4567);
    chk("relock_fd_valid_chg", {29'd0, bus.frame_done, bus.valid, bus.changed}, 32'h6);
    chk("an_err_sticky", 32'(bus.an_err), 32'h1);
    step(AN0, seg_of(4), 1'b1);
    chk("an_err_clr", 32'(bus.an_err), 32'h0);
    step(AN1, seg_of(3), 1'b0);
    step(AN2, BADSEG, 1'b0);
    chk("seg_err_set", 32'(bus.seg_err), 32'h1);
    step(AN3, seg_of(1), 1'b0);
    chk("seg_err_digits", 32'(digits()), 32'h1F34);
    chk("seg_err_changed", 32'(bus.changed), 32'h1);
    step(AN0, BADSEG, 1'b1);
    chk("seg_err_clr_vs_new", 32'(bus.seg_err), 32'h1);
    step(AN1, seg_of(3), 1'b1);
    chk("seg_err_clr", 32'(bus.seg_err), 32'h0);
    step(AN2, seg_of(2), 1'b0);
    step(AN3, seg_of(1), 1'b0);
    chk("bad_sec0_digits", 32'(digits()), 32'h123F);

    // reset mid-frame
    step(AN0, seg_of(4), 1'b0);
    step(AN1, seg_of(3), 1'b0);
    rst = 1'b1;
    step(AN2, seg_of(2), 1'b0);
    rst = 1'b0;
    chk("midrst_digits", 32'(digits()), 32'h0);
    chk("midrst_flags", {28'd0, bus.locked, bus.valid, bus.frame_done, bus.seg_err}, 32'h0);
    step(AN3, seg_of(1), 1'b0);
    chk("midrst_no_fd", {30'd0, bus.frame_done, bus.locked}, 32'h0);
    frame(5, 6, 7, 8);
    chk("midrst_relock_fd", {29'd0, bus.frame_done, bus.locked, bus.changed}, 32'h6);
    chk("midrst_digits2", 32'(digits()), 32'h5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
